// File: rtl/sdram_traffic_gen_if.sv
// Request/response user port between the traffic generator (master) and the
// SDRAM controller (slave).
interface sdram_traffic_gen_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    logic                  request;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  response;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output request, write_enable, address, write_data,
        input  response, read_data
    );

    modport slave (
        input  request, write_enable, address, write_data,
        output response, read_data
    );
endinterface

// File: rtl/sdram_traffic_gen.sv
// Write-pass then read-verify-pass traffic generator for the SDRAM user port.
// Optional per-request latency tracking: define SDRAM_TRAFFIC_GEN_LATENCY_EN.
module sdram_traffic_gen #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 13,
    parameter int ADDR_BASE      = 0,
    parameter int ADDR_COUNT     = 16,
    parameter int GAP_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [31:0]           seed_i,
    sdram_traffic_gen_if.master   mem,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [15:0]           error_count_o,
    output logic [ADDR_WIDTH-1:0] first_error_address_o,
    output logic [15:0]           max_latency_o
);
    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, WR_GAP, RD_REQ, RD_WAIT, RD_GAP, DONE
    } state_t;

    localparam logic [31:0] LAST_IDX = 32'(ADDR_COUNT - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [31:0] DW_U     = 32'(DATA_WIDTH);

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [31:0]           seed_q, seed_d, lfsr_q, lfsr_d;
    logic [31:0]           index_q, index_d, wait_q, wait_d;
    logic [7:0]            gap_q, gap_d;
    logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                  timeout_q, timeout_d;
    logic [15:0]           err_q, err_d;
    logic [ADDR_WIDTH-1:0] fea_q, fea_d;
`ifdef SDRAM_TRAFFIC_GEN_LATENCY_EN
    logic [15:0]           lat_q, lat_d, max_lat_q, max_lat_d;
`endif

    logic [ADDR_WIDTH-1:0] addr_w;
    logic [31:0]           pat_full;
    logic [DATA_WIDTH-1:0] pat_w;
    logic                  adv, is_rd;

    assign addr_w = ADDR_WIDTH'(32'(ADDR_BASE) + index_q);

    // Pattern for the current index; the LFSR holds its own state.
    always_comb begin
        pat_full = seed_q ^ 32'(addr_w);
        case (mode_q)
            2'd1:    pat_full = 32'd1 << ((index_q + 32'(seed_q[4:0])) % DW_U);
            2'd2:    pat_full = lfsr_q;
            default: ;
        endcase
    end
    assign pat_w = DATA_WIDTH'(pat_full);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        lfsr_d    = lfsr_q;
        index_d   = index_q;
        wait_d    = wait_q;
        gap_d     = gap_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        fea_d     = fea_q;
`ifdef SDRAM_TRAFFIC_GEN_LATENCY_EN
        lat_d     = lat_q;
        max_lat_d = max_lat_q;
`endif
        adv   = 1'b0;
        is_rd = (state_q == RD_WAIT) || (state_q == RD_GAP);

        case (state_q)
            IDLE: if (start_i) begin
                mode_d    = (mode_i == 2'd3) ? 2'd0 : mode_i;
                seed_d    = seed_i;
                lfsr_d    = (seed_i == 32'd0) ? 32'd1 : seed_i;
                index_d   = '0;
                busy_d    = 1'b1;
                done_d    = 1'b0;
                pass_d    = 1'b0;
                timeout_d = 1'b0;
                err_d     = '0;
`ifdef SDRAM_TRAFFIC_GEN_LATENCY_EN
                max_lat_d = '0;
`endif
                state_d   = WR_REQ;
            end
            WR_REQ, RD_REQ: begin
                wait_d  = '0;
`ifdef SDRAM_TRAFFIC_GEN_LATENCY_EN
                lat_d   = 16'd1;
`endif
                state_d = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
            end
            WR_WAIT, RD_WAIT: begin
                // A response on the expiry cycle still wins over the timeout.
                if (mem.response) begin
                    if (is_rd && (mem.read_data != pat_w)) begin
                        if (err_q == 16'd0) fea_d = addr_w;
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    end
                    lfsr_d = lfsr_step(lfsr_q);
`ifdef SDRAM_TRAFFIC_GEN_LATENCY_EN
                    if (lat_q > max_lat_q) max_lat_d = lat_q;
`endif
                    if (GAP_CYCLES == 0) adv = 1'b1;
                    else begin
                        gap_d   = '0;
                        state_d = is_rd ? RD_GAP : WR_GAP;
                    end
                end else if (wait_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wait_d = wait_q + 32'd1;
`ifdef SDRAM_TRAFFIC_GEN_LATENCY_EN
                    if (lat_q != 16'hFFFF) lat_d = lat_q + 16'd1;
`endif
                end
            end
            WR_GAP, RD_GAP: begin
                if (gap_q == GAP_LAST) adv = 1'b1;
                else gap_d = gap_q + 8'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // End of a gap: next index, or switch pass (replaying the LFSR) / finish.
        if (adv) begin
            if (index_q == LAST_IDX) begin
                index_d = '0;
                if (is_rd) state_d = DONE;
                else begin
                    lfsr_d  = (seed_q == 32'd0) ? 32'd1 : seed_q;
                    state_d = RD_REQ;
                end
            end else begin
                index_d = index_q + 32'd1;
                state_d = is_rd ? RD_REQ : WR_REQ;
            end
        end

        if ((state_d == DONE) && (state_q != DONE)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_d == 16'd0) && !timeout_d;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            seed_q    <= '0;
            lfsr_q    <= '0;
            index_q   <= '0;
            wait_q    <= '0;
            gap_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            fea_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            lfsr_q    <= lfsr_d;
            index_q   <= index_d;
            wait_q    <= wait_d;
            gap_q     <= gap_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            fea_q     <= fea_d;
        end
    end

`ifdef SDRAM_TRAFFIC_GEN_LATENCY_EN
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lat_q     <= '0;
            max_lat_q <= '0;
        end else begin
            lat_q     <= lat_d;
            max_lat_q <= max_lat_d;
        end
    end
    assign max_latency_o = max_lat_q;
`else
    assign max_latency_o = '0;
`endif

    assign mem.request      = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign mem.write_enable = (state_q == WR_REQ);
    assign mem.address      = mem.request ? addr_w : '0;
    assign mem.write_data   = (state_q == WR_REQ) ? pat_w : '0;

    assign busy_o                = busy_q;
    assign done_o                = done_q;
    assign pass_o                = pass_q;
    assign timeout_o             = timeout_q;
    assign error_count_o         = err_q;
    assign first_error_address_o = fea_q;
endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Directed bench for sdram_traffic_gen: behavioural memory responder plus request log.
module tb_sdram_traffic_gen;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] seed = 32'd0;
    logic        busy, done, pass, tmo;
    logic [15:0] errc, maxl;
    logic [12:0] fea;

    int tests = 0, fails = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0, base = 0;
    logic done_prev = 1'b0;
    int          req_cyc[$];
    logic [12:0] req_addr[$];
    logic [31:0] req_data[$];
    logic        req_we[$];

    int          lat_tab[4] = '{3, 3, 3, 3};
    logic        drop_en = 1'b0, corrupt_en = 1'b0;
    logic [12:0] drop_addr = '0, corrupt_addr = '0;
    logic [31:0] mem_model[16];

    sdram_traffic_gen_if #(.DATA_WIDTH(32), .ADDR_WIDTH(13)) bus ();

    sdram_traffic_gen #(
        .DATA_WIDTH(32), .ADDR_WIDTH(13), .ADDR_BASE(0), .ADDR_COUNT(4),
        .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clock_i(clk), .reset_ni(rst_n), .start_i(start), .mode_i(mode), .seed_i(seed),
        .mem(bus), .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
        .error_count_o(errc), .first_error_address_o(fea), .max_latency_o(maxl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.request) begin
            req_cyc.push_back(cyc);
            req_addr.push_back(bus.address);
            req_data.push_back(bus.write_data);
            req_we.push_back(bus.write_enable);
        end
        if (start && !busy) start_cyc <= cyc;
        done_prev <= done;
        if (done && !done_prev) done_cyc <= cyc;
    end

    // Memory responder: answers lat_tab[addr] cycles after each request.
    initial begin
        logic [12:0] a;
        logic        w, ok;
        logic [31:0] d;
        bus.response  = 1'b0;
        bus.read_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && bus.request) begin
                a = bus.address; w = bus.write_enable; d = bus.write_data; ok = 1'b1;
                if (!(drop_en && w && a == drop_addr)) begin
                    for (int k = 0; k < lat_tab[a[1:0]]; k++) begin
                        @(posedge clk);
                        if (!rst_n) ok = 1'b0;
                    end
                    #1;
                    if (ok && rst_n) begin
                        if (w) mem_model[a[3:0]] = d;
                        else bus.read_data = mem_model[a[3:0]] ^
                                             ((corrupt_en && a == corrupt_addr) ? 32'd1 : 32'd0);
                        bus.response = 1'b1;
                        @(posedge clk); #1;
                        bus.response = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [1:0] m, input logic [31:0] s);
        base = req_cyc.size();
        @(posedge clk); #1;
        mode = m; seed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 300) begin @(posedge clk); #1; n++; end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s: done not seen within 300 cycles", name);
        end
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if ({bus.request, bus.write_enable, busy, done, pass, tmo} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got %b want 000000",
                              {bus.request, bus.write_enable, busy, done, pass, tmo});
        end
        tests++;
        if ({bus.address, bus.write_data, errc, fea, maxl} !== '0) begin
            fails++; $display("FAIL reset_values: addr %0h data %0h err %0h fea %0h lat %0h want 0",
                              bus.address, bus.write_data, errc, fea, maxl);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_phase;
        do_start(2'd0, 32'd0);
        wait_done("write_phase");
        tests++;
        if (req_cyc[base] - start_cyc !== 1) begin
            fails++; $display("FAIL first_req_latency: got %0d want 1", req_cyc[base] - start_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (req_we[base+i] !== 1'b1 || req_addr[base+i] !== 13'(i) || req_data[base+i] !== 32'(i)) begin
                fails++; $display("FAIL write_%0d: we %b addr %0h data %0h want we 1 addr %0h data %0h",
                                  i, req_we[base+i], req_addr[base+i], req_data[base+i], i, i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (req_cyc[base+i+1] - req_cyc[base+i] !== 6) begin
                fails++; $display("FAIL spacing_%0d: got %0d want 6", i, req_cyc[base+i+1] - req_cyc[base+i]);
            end
        end
    endtask

    task automatic test_clean_run;
        do_start(2'd0, 32'd0);
        wait_done("clean_run");
        tests++;
        if ({done, pass, busy, tmo} !== 4'b1100 || errc !== 16'd0) begin
            fails++; $display("FAIL clean_status: done %b pass %b busy %b tmo %b err %0d want 1 1 0 0 0",
                              done, pass, busy, tmo, errc);
        end
        tests++;
        if (req_cyc.size() - base !== 8) begin
            fails++; $display("FAIL clean_count: got %0d want 8", req_cyc.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (req_we[base+4+i] !== 1'b0 || req_addr[base+4+i] !== 13'(i)) begin
                fails++; $display("FAIL read_%0d: we %b addr %0h want we 0 addr %0h",
                                  i, req_we[base+4+i], req_addr[base+4+i], i);
            end
        end
    endtask

    task automatic test_back_to_back;
        do_start(2'd0, 32'd0);
        wait_done("b2b_first");
        @(posedge clk); #1;
        base = req_cyc.size();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if ({busy, done, bus.request} !== 3'b101) begin
            fails++; $display("FAIL b2b_restart: busy %b done %b req %b want 1 0 1", busy, done, bus.request);
        end
        wait_done("b2b_second");
        tests++;
        if (pass !== 1'b1 || req_cyc.size() - base !== 8) begin
            fails++; $display("FAIL b2b_result: pass %b reqs %0d want 1 8", pass, req_cyc.size() - base);
        end
    endtask

    task automatic test_walking;
        logic [31:0] exp_w[4] = '{32'h4000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0002};
        do_start(2'd1, 32'd30);
        wait_done("walking");
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (req_data[base+i] !== exp_w[i]) begin
                fails++; $display("FAIL walk_%0d: got %08h want %08h", i, req_data[base+i], exp_w[i]);
            end
        end
        tests++;
        if (pass !== 1'b1) begin fails++; $display("FAIL walk_pass: got %b want 1", pass); end
    endtask

    task automatic test_corrupt;
        logic [31:0] exp_l[4] = '{32'h0000_ACE1, 32'h8020_5673, 32'hC030_2B3A, 32'h6018_159D};
        corrupt_en = 1'b1; corrupt_addr = 13'd2;
        do_start(2'd2, 32'h0000_ACE1);
        wait_done("corrupt");
        corrupt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (req_data[base+i] !== exp_l[i]) begin
                fails++; $display("FAIL lfsr_%0d: got %08h want %08h", i, req_data[base+i], exp_l[i]);
            end
        end
        tests++;
        if (errc !== 16'd1 || fea !== 13'd2 || pass !== 1'b0 || done !== 1'b1) begin
            fails++; $display("FAIL corrupt_status: err %0d fea %0d pass %b done %b want 1 2 0 1",
                              errc, fea, pass, done);
        end
    endtask

    task automatic test_timeout;
        drop_en = 1'b1; drop_addr = 13'd1;
        do_start(2'd0, 32'd0);
        wait_done("timeout");
        drop_en = 1'b0;
        @(negedge clk);
        tests++;
        if ({tmo, done, pass, busy} !== 4'b1100) begin
            fails++; $display("FAIL timeout_status: tmo %b done %b pass %b busy %b want 1 1 0 0",
                              tmo, done, pass, busy);
        end
        tests++;
        if (req_cyc.size() - base !== 2 || done_cyc - req_cyc[base+1] > 18) begin
            fails++; $display("FAIL timeout_timing: reqs %0d delay %0d want 2 and <=18",
                              req_cyc.size() - base, done_cyc - req_cyc[base+1]);
        end
    endtask

    task automatic test_reset_midrun;
        int n = 0;
        do_start(2'd0, 32'd0);
        while (!(bus.request && !bus.write_enable) && n < 300) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.request, busy, done} !== 3'b000 || n >= 300) begin
            fails++; $display("FAIL midrun_reset: req %b busy %b done %b wait %0d want 0 0 0",
                              bus.request, busy, done, n);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_start(2'd0, 32'd0);
        wait_done("after_reset");
        tests++;
        if (pass !== 1'b1 || tmo !== 1'b0 || req_cyc.size() - base !== 8) begin
            fails++; $display("FAIL after_reset_run: pass %b tmo %b reqs %0d want 1 0 8",
                              pass, tmo, req_cyc.size() - base);
        end
    endtask

    task automatic test_start_ignored;
        do_start(2'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1; mode = 2'd1; seed = 32'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done("start_ignored");
        tests++;
        if (req_cyc.size() - base !== 8 || req_data[base+2] !== 32'd2 || pass !== 1'b1) begin
            fails++; $display("FAIL start_ignored: reqs %0d data2 %0h pass %b want 8 2 1",
                              req_cyc.size() - base, req_data[base+2], pass);
        end
    endtask

    task automatic test_latency;
        logic [15:0] exp_lat;
`ifdef SDRAM_TRAFFIC_GEN_LATENCY_EN
        exp_lat = 16'd7;
`else
        exp_lat = 16'd0;
`endif
        lat_tab = '{3, 7, 5, 4};
        do_start(2'd0, 32'd0);
        wait_done("latency");
        lat_tab = '{3, 3, 3, 3};
        tests++;
        if (maxl !== exp_lat || pass !== 1'b1) begin
            fails++; $display("FAIL max_latency: got %0d pass %b want %0d 1", maxl, pass, exp_lat);
        end
    endtask

    initial begin
        test_reset();
        test_write_phase();
        test_clean_run();
        test_back_to_back();
        test_walking();
        test_corrupt();
        test_timeout();
        test_reset_midrun();
        test_start_ignored();
        test_latency();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule

// File: doc/sdram_traffic_gen.md
Name: sdram_traffic_gen

Overview:
- Synthesizable, self-checking traffic generator for the sdram_controller request/response port.
- Replaces hand-scripted bench stimulus with a parametrised write-pass then read-verify-pass over an address window.
- Supports three data patterns, a configurable inter-request gap, a response timeout, and error capture.
- Sits between a start/status register block (or the bench top) and the controller's user port.

Parameters:
- DATA_WIDTH, 32, controller data width, legal 8..32.
- ADDR_WIDTH, 13, controller address width.
- ADDR_BASE, 0, first address of the test window.
- ADDR_COUNT, 16, number of words per pass, legal 1..2^ADDR_WIDTH.
- GAP_CYCLES, 50, idle cycles after each response before the next request, legal 0..255.
- TIMEOUT_CYCLES, 1024, maximum cycles waited for a response.

Ports:
- clock, input, 1, single clock for the whole block, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, one-cycle pulse that begins a run; ignored while busy=1.
- mode, input, 2, pattern select sampled on start: 0=address^seed, 1=walking one, 2=LFSR, 3=treated as 0.
- seed, input, 32, pattern seed sampled on start.
- request, output, 1, one-cycle request pulse to the controller.
- write_enable, output, 1, high with request for writes.
- address, output, ADDR_WIDTH, request address, valid while request=1.
- write_data, output, DATA_WIDTH, write data, valid while request=1.
- response, input, 1, controller completion pulse.
- read_data, input, DATA_WIDTH, read data, valid with response on reads.
- busy, output, 1, run in progress.
- done, output, 1, level; set at run end, cleared on start.
- pass, output, 1, valid when done=1: no mismatch and no timeout.
- timeout, output, 1, sticky until start; a wait exceeded TIMEOUT_CYCLES.
- error_count, output, 16, saturating count of read mismatches.
- first_error_address, output, ADDR_WIDTH, address of the first mismatch.
- max_latency, output, 16, feature output; see Optional Feature.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; all outputs 0, including request, write_enable, address, write_data, busy, done, pass, timeout, error_count, first_error_address and max_latency.
- Reset mid-run: outputs drop immediately and the run is abandoned.
- State sequence: IDLE -> WR_REQ -> WR_WAIT -> WR_GAP -> ... -> RD_REQ -> RD_WAIT -> RD_GAP -> ... -> DONE -> IDLE.
- IDLE: on start, latch mode and seed, clear done, timeout, error_count and max_latency, set index=0 and busy=1, load the pattern state, go to WR_REQ.
- WR_REQ: request=1 and write_enable=1 for exactly 1 cycle; address=ADDR_BASE+index mod 2^ADDR_WIDTH; write_data=pattern(index). Next state WR_WAIT.
- WR_WAIT: wait counter increments each cycle.
  - On response: advance the pattern and go to WR_GAP.
  - If the counter reaches TIMEOUT_CYCLES with no response: set timeout=1 and go to DONE.
- WR_GAP: wait GAP_CYCLES cycles; GAP_CYCLES=0 means a direct transition.
  - index<ADDR_COUNT-1: index++, go to WR_REQ.
  - index=ADDR_COUNT-1: index=0, reload the pattern state from the latched seed, go to RD_REQ.
- RD_REQ: request=1 and write_enable=0 for 1 cycle, same address rule. Next state RD_WAIT.
- RD_WAIT: same timeout rule as WR_WAIT.
  - On response: compare read_data against pattern(index).
  - On mismatch: error_count increments, saturating at 0xFFFF; on the first mismatch, capture first_error_address.
  - Then go to RD_GAP.
- RD_GAP: same as WR_GAP; at the last index, go to DONE.
- DONE: 1 cycle; busy=0, done=1, pass=(error_count==0 && !timeout); go to IDLE. done, pass and the status outputs hold until the next start.
- Latency: first request 1 cycle after start. Request-to-request spacing = response latency + GAP_CYCLES + 1.
- A response seen outside WR_WAIT or RD_WAIT is ignored.
- A response on the same cycle as the timeout expiry counts as a response, not a timeout.
- start on the same cycle as done is accepted: IDLE samples start on the cycle after DONE.
- Patterns, truncated to DATA_WIDTH:
  - Mode 0: seed ^ zero-extended address.
  - Mode 1: 1 << ((index + seed[4:0]) mod DATA_WIDTH).
  - Mode 2: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1. Seeded with seed, or with 1 if seed==0. Steps once per accepted response. The read pass replays the identical sequence.

Optional Feature:
- Macro: SDRAM_TRAFFIC_GEN_LATENCY_EN.
- Defined: per-request latency counter counts cycles from request to response.
  - max_latency holds the largest value seen in the run, saturating at 0xFFFF.
  - It is cleared on start and excludes timed-out requests.
- Not defined: max_latency is tied to 0 and no latency counter is built.

Test Plan:
- Write phase: responder returns response 3 cycles after request; ADDR_COUNT=4, GAP_CYCLES=2, mode 0, seed 0 -> writes to addresses 0..3 with data 0..3; requests spaced 6 cycles apart.
- Clean run: responder models memory correctly -> reads 0..3, done=1, pass=1, error_count=0, timeout=0.
- Corrupt read: responder flips bit 0 on the read of address 2 (mode 2, seed 0xACE1) -> error_count=1, first_error_address=2, pass=0.
- Timeout: responder never answers the 2nd write, TIMEOUT_CYCLES=16 -> timeout=1, done=1, pass=0, busy=0 within 18 cycles of that request.
- Reset mid-run: reset driven low during RD_WAIT -> request=0, busy=0, done=0 immediately; a new start completes a clean run.
- Optional feature, latency: SDRAM_TRAFFIC_GEN_LATENCY_EN defined, responder latencies 3,7,5,4 -> max_latency=7. Macro undefined -> max_latency=0.
